// File: rtl/frame_load_sequencer.sv
// Front-end sequencer for one CNN inference: steers the single byte stream into weight RAM,
// then data RAM, then drains the pipeline while generating cnt, conv_vld and frame_done.
module frame_load_sequencer #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int K        = 3,
    parameter int N_WEIGHT = 54,
    parameter int DRAIN    = 4,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             skip_w,
    input  logic             in_vld,
    input  logic [7:0]       din,
    output logic             weight_wen,
    output logic             data_wen,
    output logic [7:0]       ram_din,
    output logic [CNT_W-1:0] cnt,
    output logic             conv_vld,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int WCNT_W = $clog2(N_WEIGHT + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  WIN_ROW  = ROW_W'(K - 1);
    localparam logic [COL_W-1:0]  WIN_COL  = COL_W'(K - 1);
    localparam logic [WCNT_W-1:0] W_LAST   = WCNT_W'(N_WEIGHT - 1);
    localparam logic [CNT_W-1:0]  D_LAST   = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0]  END_LAST = CNT_W'(IMG_W * IMG_H + DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_D = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              clear_frame;
    logic              err_set;

    assign ram_din   = din;
    assign dbg_state = state;

    always_comb begin
        state_next  = state;
        clear_frame = 1'b0;
        err_set     = 1'b0;
        weight_wen  = 1'b0;
        data_wen    = 1'b0;
        case (state)
            S_IDLE: begin
                // A byte arriving alongside start is dropped; the first byte lands next cycle.
                if (start) begin
                    clear_frame = 1'b1;
                    state_next  = skip_w ? S_LOAD_D : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                weight_wen = in_vld;
                err_set    = start;
                if (in_vld && wcnt == W_LAST) state_next = S_LOAD_D;
            end
            S_LOAD_D: begin
                data_wen = in_vld;
                err_set  = start;
                if (in_vld && cnt == D_LAST) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                err_set = start | in_vld;
                if (cnt == END_LAST) state_next = S_DONE;
            end
            S_DONE: begin
                err_set    = start | in_vld;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            conv_vld   <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            wcnt       <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != S_IDLE);
            frame_done <= (state_next == S_DONE);
            conv_vld   <= data_wen && (row >= WIN_ROW) && (col >= WIN_COL);
            if (clear_frame) begin
                cnt  <= '0;
                wcnt <= '0;
                row  <= '0;
                col  <= '0;
                err  <= 1'b0;
            end else begin
                if (err_set) err <= 1'b1;
                if (weight_wen) wcnt <= wcnt + 1'b1;
                // cnt keeps counting through the drain tail so downstream stages stay in phase.
                if (data_wen || state == S_DRAIN) cnt <= cnt + 1'b1;
                if (data_wen) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_load_sequencer.sv
// Scoreboard bench for frame_load_sequencer: drivers push expected strobes into queues,
// a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_frame_load_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       skip_w = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] din = 8'h00;
    logic       weight_wen, data_wen, conv_vld, busy, frame_done, err;
    logic [7:0] ram_din;
    logic [6:0] cnt;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  wq[$];
    logic [14:0] dq[$];
    logic [6:0]  cq[$];
    logic [31:0] fq[$];
    logic        fe_q[$];

    frame_load_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_w(skip_w), .in_vld(in_vld),
        .din(din), .weight_wen(weight_wen), .data_wen(data_wen), .ram_din(ram_din),
        .cnt(cnt), .conv_vld(conv_vld), .busy(busy), .frame_done(frame_done),
        .err(err), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got strobe expected none (cycle %0d)", name, cyc);
    endtask

    // drive one cycle of inputs, held from just after a rising edge
    task automatic step(input logic s, input logic sk, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        start  = s;
        skip_w = sk;
        in_vld = v;
        din    = d;
    endtask

    task automatic send_frame(input bit skip, input bit gap, input bit inj);
        int         sc;
        int         last;
        int         g;
        logic [7:0] b;
        step(1'b1, skip, 1'b1, 8'hEE);
        sc = cyc;
        g  = 0;
        if (!skip) begin
            for (int i = 0; i < 54; i++) begin
                if (gap && g % 3 == 2) begin
                    step(1'b0, 1'b0, 1'b0, 8'h00);
                    g++;
                end
                b = 8'(i * 5 + 1);
                wq.push_back(b);
                step(1'b0, 1'b0, 1'b1, b);
                g++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            if (gap && g % 3 == 2) begin
                step(1'b0, 1'b0, 1'b0, 8'h00);
                g++;
            end
            if (inj && i == 10) begin
                step(1'b1, 1'b0, 1'b0, 8'h00);
                step(1'b0, 1'b0, 1'b0, 8'h00);
                @(negedge clk);
                chk("err_on_busy_start", 32'(err), 32'd1);
                chk("busy_start_ignored", 32'(dbg_state), 32'd2);
            end
            b = 8'(8'hA0 ^ i);
            dq.push_back({b, 7'(i)});
            if (i / 8 >= 2 && i % 8 >= 2) cq.push_back(7'(i + 1));
            step(1'b0, 1'b0, 1'b1, b);
            g++;
            if (i == 0) begin
                @(negedge clk);
                chk("busy_in_frame", 32'(busy), 32'd1);
                chk("err_cleared_by_start", 32'(err), 32'd0);
            end
        end
        last = cyc;
        if (gap || inj) fq.push_back(32'(last + 5));
        else if (skip)  fq.push_back(32'(sc + 69));
        else            fq.push_back(32'(sc + 123));
        fe_q.push_back(inj);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, inj && j == 1, 8'h33);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wen_exclusive", 32'(weight_wen & data_wen), 32'd0);
            if (weight_wen) begin
                if (wq.size() == 0) unexpected("weight_wen");
                else chk("weight_byte", 32'(ram_din), 32'(wq.pop_front()));
            end
            if (data_wen) begin
                if (dq.size() == 0) unexpected("data_wen");
                else begin
                    logic [14:0] e;
                    e = dq.pop_front();
                    chk("data_byte", 32'(ram_din), 32'(e[14:7]));
                    chk("data_cnt", 32'(cnt), 32'(e[6:0]));
                end
            end
            if (conv_vld) begin
                if (cq.size() == 0) unexpected("conv_vld");
                else chk("conv_vld_cnt", 32'(cnt), 32'(cq.pop_front()));
            end
            if (frame_done) begin
                if (fq.size() == 0) unexpected("frame_done");
                else begin
                    chk("done_cycle", 32'(cyc), fq.pop_front());
                    chk("done_err", 32'(err), 32'(fe_q.pop_front()));
                    chk("done_cnt", 32'(cnt), 32'd68);
                end
            end
        end
    end

    initial begin
        // reset held with start and in_vld asserted
        rst_n  = 1'b0;
        start  = 1'b1;
        in_vld = 1'b1;
        din    = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_weight_wen", 32'(weight_wen), 32'd0);
        chk("rst_data_wen", 32'(data_wen), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_conv_vld", 32'(conv_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        start  = 1'b0;
        in_vld = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_state", 32'(dbg_state), 32'd0);

        send_frame(1'b0, 1'b0, 1'b0);   // contiguous full frame
        send_frame(1'b0, 1'b1, 1'b0);   // gapped stream
        send_frame(1'b1, 1'b0, 1'b0);   // reuse weights
        send_frame(1'b1, 1'b0, 1'b1);   // protocol errors
        @(negedge clk);
        chk("err_sticky_idle", 32'(err), 32'd1);
        send_frame(1'b0, 1'b0, 1'b0);   // start clears err

        // abort mid data load
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            dq.push_back({8'(8'hA0 ^ i), 7'(i)});
            if (i / 8 >= 2 && i % 8 >= 2) cq.push_back(7'(i + 1));
            step(1'b0, 1'b0, 1'b1, 8'(8'hA0 ^ i));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cnt", 32'(cnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(1'b0, 1'b0, 1'b0);

        repeat (5) step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        chk("cq_drained", 32'(cq.size()), 32'd0);
        chk("fq_drained", 32'(fq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
